// File: rtl/spin_pattern_decoder_pkg.sv
// spin_pattern_decoder_pkg
//   Shared constants for the spinner loopback monitor:
//   - 7-segment drive patterns (8-bit, dp bit kept at 0)
//   - 3-bit phase codes reported on Phase
//   - FSM state encoding
//   - pattern decode and ring-neighbour helper functions
package spin_pattern_decoder_pkg;

    // Bit 7 is the decimal point and never carries phase information.
    localparam logic [7:0] SEG_MASK  = 8'h7F;

    localparam logic [7:0] SEG_BLANK = 8'b0000_0000;
    localparam logic [7:0] SEG_PH1   = 8'b0110_0010;
    localparam logic [7:0] SEG_PH2   = 8'b0110_0001;
    localparam logic [7:0] SEG_PH3   = 8'b0010_0011;
    localparam logic [7:0] SEG_PH4   = 8'b0100_0011;
    localparam logic [7:0] SEG_FULL  = 8'b0110_0011;

    localparam logic [2:0] CODE_BLANK   = 3'b000;
    localparam logic [2:0] CODE_PH1     = 3'b001;
    localparam logic [2:0] CODE_PH2     = 3'b010;
    localparam logic [2:0] CODE_PH3     = 3'b011;
    localparam logic [2:0] CODE_PH4     = 3'b100;
    localparam logic [2:0] CODE_FULL    = 3'b101;
    // Internal marker only; never reaches the Phase output.
    localparam logic [2:0] CODE_ILLEGAL = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_SYNC = 2'b01;
    localparam logic [1:0] ST_SPIN = 2'b10;
    localparam logic [1:0] ST_HOLD = 2'b11;

    function automatic logic [2:0] seg_decode(input logic [7:0] seg);
        logic [7:0] m;
        m = seg & SEG_MASK;
        case (m)
            SEG_BLANK: return CODE_BLANK;
            SEG_PH1:   return CODE_PH1;
            SEG_PH2:   return CODE_PH2;
            SEG_PH3:   return CODE_PH3;
            SEG_PH4:   return CODE_PH4;
            SEG_FULL:  return CODE_FULL;
            default:   return CODE_ILLEGAL;
        endcase
    endfunction

    // Forward neighbour on the 1..4 ring: 1->2->3->4->1.
    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p == CODE_PH4) ? CODE_PH1 : p + 3'd1;
    endfunction

    // Reverse neighbour on the 1..4 ring: 1->4->3->2->1.
    function automatic logic [2:0] prev_phase(input logic [2:0] p);
        return (p == CODE_PH1) ? CODE_PH4 : p - 3'd1;
    endfunction

endpackage

// File: rtl/spin_pattern_decoder_if.sv
// spin_pattern_decoder_if
//   Bundles the segment-bus inputs and the status outputs of the monitor.
//   master : the driver side (test harness / system) - drives SampleEn,
//            SSegIn, ErrClr and observes the status signals.
//   slave  : the monitor itself.
//   Signals:
//     SampleEn  sample strobe          SSegIn   8-bit segment bus (bit7 = dp)
//     ErrClr    clear sticky Error     Phase    last accepted phase code
//     NewPhase  accepted-change pulse  Dir      1 = forward rotation
//     Spinning  FSM in SPIN            RevCount completed revolutions
//     RevWrap   RevCount wrap pulse    Error    sticky error flag
interface spin_pattern_decoder_if #(
    parameter int REV_W = 8
);
    logic             SampleEn;
    logic [7:0]       SSegIn;
    logic             ErrClr;
    logic [2:0]       Phase;
    logic             NewPhase;
    logic             Dir;
    logic             Spinning;
    logic [REV_W-1:0] RevCount;
    logic             RevWrap;
    logic             Error;

    modport master (
        output SampleEn, SSegIn, ErrClr,
        input  Phase, NewPhase, Dir, Spinning, RevCount, RevWrap, Error
    );

    modport slave (
        input  SampleEn, SSegIn, ErrClr,
        output Phase, NewPhase, Dir, Spinning, RevCount, RevWrap, Error
    );
endinterface

// File: rtl/spin_pattern_decoder_seg_debounce.sv
// seg_debounce
//   Debounces the sampled segment bus. A pattern must be seen on STABLE_CNT
//   consecutive strobed samples before it is accepted, and a pattern equal to
//   the currently accepted one is never re-accepted.
//   Ports:
//     Clk, nReset  clock, synchronous active-low reset
//     sample_en    sample strobe
//     seg_in       raw 8-bit segment bus (dp masked here)
//     accept       combinational strobe, high in the cycle whose edge accepts
//     accept_pat   pattern being accepted (valid while accept is high)
module seg_debounce #(
    parameter int STABLE_CNT = 2
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       sample_en,
    input  logic [7:0] seg_in,
    output logic       accept,
    output logic [7:0] accept_pat
);
    import spin_pattern_decoder_pkg::*;

    localparam int              CNT_W   = $clog2(STABLE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

    logic [7:0]       seg_m;
    logic [7:0]       cand;
    logic [7:0]       cand_nxt;
    logic [7:0]       acc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    assign seg_m = seg_in & SEG_MASK;

    always_comb begin
        cand_nxt = cand;
        cnt_nxt  = cnt;
        if (sample_en) begin
            if (seg_m == cand) begin
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + 1'b1;
                end
            end else begin
                cand_nxt = seg_m;
                cnt_nxt  = CNT_W'(1);
            end
        end
    end

    // Once a candidate is accepted it equals acc, so a saturated count can
    // never fire a second accept for the same pattern.
    assign accept     = sample_en && (cnt_nxt == CNT_MAX) && (cand_nxt != acc);
    assign accept_pat = cand_nxt;

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            cand <= SEG_BLANK;
            cnt  <= '0;
            acc  <= SEG_BLANK;
        end else begin
            cand <= cand_nxt;
            cnt  <= cnt_nxt;
            if (accept) begin
                acc <= cand_nxt;
            end
        end
    end
endmodule

// File: rtl/spin_pattern_decoder.sv
// spin_pattern_decoder
//   Receive-side monitor for the spinning-disk 7-segment drive bus. Debounces
//   SSegIn, decodes accepted patterns to phase codes and tracks rotation with
//   an IDLE/SYNC/SPIN/HOLD FSM, reporting direction, revolutions and errors.
//   Parameters:
//     STABLE_CNT  equal samples needed before a pattern is accepted (>=1)
//     REV_W       revolution counter width
//   Ports:
//     Clk, nReset  clock, synchronous active-low reset
//     bus          spin_pattern_decoder_if slave modport
//                  (SampleEn, SSegIn, ErrClr in; Phase, NewPhase, Dir,
//                   Spinning, RevCount, RevWrap, Error out)
module spin_pattern_decoder #(
    parameter int STABLE_CNT = 2,
    parameter int REV_W      = 8
) (
    input  logic                  Clk,
    input  logic                  nReset,
    spin_pattern_decoder_if.slave bus
);
    import spin_pattern_decoder_pkg::*;

    logic             accept;
    logic [7:0]       acc_pat;
    logic [2:0]       code;
    logic             legal;
    logic             fwd;
    logic             rev;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [2:0]       phase;
    logic             new_phase;
    logic             dir;
    logic             dir_nxt;
    logic [REV_W-1:0] rev_count;
    logic             rev_wrap;
    logic             rev_inc;
    logic             error;
    logic             err_set;

    seg_debounce #(
        .STABLE_CNT(STABLE_CNT)
    ) u_debounce (
        .Clk        (Clk),
        .nReset     (nReset),
        .sample_en  (bus.SampleEn),
        .seg_in     (bus.SSegIn),
        .accept     (accept),
        .accept_pat (acc_pat)
    );

    assign code  = seg_decode(acc_pat);
    assign legal = (code != CODE_ILLEGAL);
    // Neighbour tests against the last accepted phase; only meaningful in
    // SYNC/SPIN where phase is guaranteed to hold 1..4.
    assign fwd   = (code == next_phase(phase));
    assign rev   = (code == prev_phase(phase));

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir;
        err_set   = 1'b0;
        rev_inc   = 1'b0;
        if (accept) begin
            if (!legal) begin
                err_set   = 1'b1;
                state_nxt = ST_IDLE;
            end else if (code == CODE_BLANK) begin
                state_nxt = ST_IDLE;
            end else if (code == CODE_FULL) begin
                state_nxt = ST_HOLD;
            end else begin
                case (state)
                    ST_IDLE, ST_HOLD: begin
                        state_nxt = ST_SYNC;
                    end
                    default: begin
                        if (fwd || rev) begin
                            state_nxt = ST_SPIN;
                            dir_nxt   = fwd;
                            // A neighbour step into ph1 is 4->1 forward or
                            // 2->1 reverse; only counted once already spinning.
                            rev_inc   = (state == ST_SPIN) && (code == CODE_PH1);
                        end else begin
                            err_set   = 1'b1;
                            state_nxt = ST_SYNC;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state     <= ST_IDLE;
            phase     <= CODE_BLANK;
            new_phase <= 1'b0;
            dir       <= 1'b1;
            rev_count <= '0;
            rev_wrap  <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            new_phase <= accept && legal;
            if (accept && legal) begin
                phase <= code;
            end
            rev_wrap <= rev_inc && (rev_count == {REV_W{1'b1}});
            if (rev_inc) begin
                rev_count <= rev_count + 1'b1;
            end
            // A new error on the same edge as ErrClr must not be lost.
            if (err_set) begin
                error <= 1'b1;
            end else if (bus.ErrClr) begin
                error <= 1'b0;
            end
        end
    end

    assign bus.Phase    = phase;
    assign bus.NewPhase = new_phase;
    assign bus.Dir      = dir;
    assign bus.Spinning = (state == ST_SPIN);
    assign bus.RevCount = rev_count;
    assign bus.RevWrap  = rev_wrap;
    assign bus.Error    = error;
endmodule

// File: tb/tb_spin_pattern_decoder.sv
// tb_spin_pattern_decoder
//   Directed scenarios with literal expectations followed by randomized
//   pattern runs; a behavioural model predicts every output each cycle.
`timescale 1ns/1ps
module tb_spin_pattern_decoder;
    localparam int STABLE_CNT = 2;
    localparam int REV_W      = 8;

    localparam logic [7:0] P_BLANK = 8'h00;
    localparam logic [7:0] P_PH1   = 8'h62;
    localparam logic [7:0] P_PH2   = 8'h61;
    localparam logic [7:0] P_PH3   = 8'h23;
    localparam logic [7:0] P_PH4   = 8'h43;
    localparam logic [7:0] P_FULL  = 8'h63;
    localparam logic [7:0] P_BAD   = 8'h07;

    logic Clk = 1'b0;
    logic nReset;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 Clk = ~Clk;

    spin_pattern_decoder_if #(.REV_W(REV_W)) bus ();

    spin_pattern_decoder #(
        .STABLE_CNT (STABLE_CNT),
        .REV_W      (REV_W)
    ) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States: 0 idle, 1 sync, 2 spin, 3 hold.
    int          m_state;
    logic [2:0]  m_phase;
    logic        m_newphase, m_dir, m_revwrap, m_err;
    int unsigned m_rev;
    logic [6:0]  m_acc;
    logic [6:0]  hist[$];
    int          code, d;
    logic        set_err, stable;

    function automatic int seg_code(input logic [6:0] s);
        case (s)
            7'b0000000: return 0;
            7'b1100010: return 1;
            7'b1100001: return 2;
            7'b0100011: return 3;
            7'b1000011: return 4;
            7'b1100011: return 5;
            default:    return -1;
        endcase
    endfunction

    always @(posedge Clk) begin
        m_newphase = 1'b0;
        m_revwrap  = 1'b0;
        set_err    = 1'b0;
        if (!nReset) begin
            m_state = 0; m_phase = 3'd0; m_dir = 1'b1; m_rev = 0;
            m_err = 1'b0; m_acc = 7'd0; hist.delete();
        end else begin
            if (bus.SampleEn) begin
                hist.push_back(bus.SSegIn[6:0]);
                if (hist.size() > STABLE_CNT) void'(hist.pop_front());
                stable = (hist.size() == STABLE_CNT);
                foreach (hist[i]) if (hist[i] != hist[0]) stable = 1'b0;
                if (stable && hist[0] != m_acc) begin
                    m_acc = hist[0];
                    code  = seg_code(m_acc);
                    if (code < 0) begin
                        set_err = 1'b1;
                        m_state = 0;
                    end else begin
                        m_newphase = 1'b1;
                        if (code == 0) m_state = 0;
                        else if (code == 5) m_state = 3;
                        else if (m_state == 0 || m_state == 3) m_state = 1;
                        else begin
                            d = (code - int'(m_phase) + 4) % 4;
                            if (d == 1 || d == 3) begin
                                if (m_state == 2 && code == 1) begin
                                    if (m_rev == (1 << REV_W) - 1) begin
                                        m_rev = 0; m_revwrap = 1'b1;
                                    end else m_rev++;
                                end
                                m_dir   = (d == 1);
                                m_state = 2;
                            end else begin
                                set_err = 1'b1;
                                m_state = 1;
                            end
                        end
                        m_phase = 3'(code);
                    end
                end
            end
            if (set_err) m_err = 1'b1;
            else if (bus.ErrClr) m_err = 1'b0;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge Clk) begin
        if (chk_en) begin
            chk("cyc_Phase",    32'(bus.Phase),    32'(m_phase));
            chk("cyc_NewPhase", 32'(bus.NewPhase), 32'(m_newphase));
            chk("cyc_Dir",      32'(bus.Dir),      32'(m_dir));
            chk("cyc_Spinning", 32'(bus.Spinning), 32'(m_state == 2));
            chk("cyc_RevCount", 32'(bus.RevCount), m_rev);
            chk("cyc_RevWrap",  32'(bus.RevWrap),  32'(m_revwrap));
            chk("cyc_Error",    32'(bus.Error),    32'(m_err));
        end
    end

    // ---------------- stimulus ----------------
    task automatic feed(input logic [7:0] pat, input int n);
        for (int i = 0; i < n; i++) begin
            bus.SampleEn = 1'b1;
            bus.SSegIn   = pat;
            @(posedge Clk); #1;
        end
        bus.SampleEn = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.SampleEn = 1'b0;
        repeat (n) begin @(posedge Clk); #1; end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_Phase"},    32'(bus.Phase),    32'd0);
        chk({tag, "_NewPhase"}, 32'(bus.NewPhase), 32'd0);
        chk({tag, "_Dir"},      32'(bus.Dir),      32'd1);
        chk({tag, "_Spinning"}, 32'(bus.Spinning), 32'd0);
        chk({tag, "_RevCount"}, 32'(bus.RevCount), 32'd0);
        chk({tag, "_RevWrap"},  32'(bus.RevWrap),  32'd0);
        chk({tag, "_Error"},    32'(bus.Error),    32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ring [4];
        int         idx, r, len, pick;
        logic [7:0] pat;

        ring[0] = P_PH1; ring[1] = P_PH2; ring[2] = P_PH3; ring[3] = P_PH4;
        bus.SampleEn = 1'b0; bus.SSegIn = 8'h00; bus.ErrClr = 1'b0; nReset = 1'b0;
        @(posedge Clk); #1; @(posedge Clk); #1;
        chk_en = 1'b1;
        chk_reset_vals("reset");
        nReset = 1'b1;

        // 1: first phase acquires sync
        feed(P_PH1, 2);
        chk("t1_Phase", 32'(bus.Phase), 32'd1);
        chk("t1_NewPhase", 32'(bus.NewPhase), 32'd1);
        chk("t1_Spinning", 32'(bus.Spinning), 32'd0);
        chk("t1_model_Phase", 32'(m_phase), 32'd1);
        idle(1);
        chk("t1_NewPhase_drop", 32'(bus.NewPhase), 32'd0);

        // 2: forward revolutions and counter wrap
        feed(P_PH2, 2); feed(P_PH3, 2); feed(P_PH4, 2); feed(P_PH1, 2);
        chk("t2_Dir", 32'(bus.Dir), 32'd1);
        chk("t2_Spinning", 32'(bus.Spinning), 32'd1);
        chk("t2_RevCount", 32'(bus.RevCount), 32'd1);
        chk("t2_model_Rev", m_rev, 32'd1);
        for (int k = 0; k < 255; k++) begin
            feed(P_PH2, 2); feed(P_PH3, 2); feed(P_PH4, 2); feed(P_PH1, 2);
            if (k == 253) chk("t2_RevCount_255", 32'(bus.RevCount), 32'd255);
        end
        chk("t2_RevCount_wrap", 32'(bus.RevCount), 32'd0);
        chk("t2_RevWrap", 32'(bus.RevWrap), 32'd1);
        idle(1);
        chk("t2_RevWrap_drop", 32'(bus.RevWrap), 32'd0);

        // 3: direction reversal, reverse revolution
        feed(P_PH2, 2); feed(P_PH3, 2); feed(P_PH2, 2);
        chk("t3_Dir", 32'(bus.Dir), 32'd0);
        chk("t3_Error", 32'(bus.Error), 32'd0);
        feed(P_PH1, 2);
        chk("t3_RevCount", 32'(bus.RevCount), 32'd1);

        // 4: skipped phase, clear, clear colliding with new error
        feed(P_PH3, 2);
        chk("t4_Error", 32'(bus.Error), 32'd1);
        chk("t4_Spinning", 32'(bus.Spinning), 32'd0);
        bus.ErrClr = 1'b1; idle(1); bus.ErrClr = 1'b0;
        chk("t4_ErrClr", 32'(bus.Error), 32'd0);
        bus.ErrClr = 1'b1; feed(P_BAD, 2); bus.ErrClr = 1'b0;
        chk("t4_set_wins", 32'(bus.Error), 32'd1);
        chk("t4_Phase_kept", 32'(bus.Phase), 32'd3);
        chk("t4_no_NewPhase", 32'(bus.NewPhase), 32'd0);

        // 5: single-sample glitch is rejected
        feed(P_PH2, 2);
        chk("t5_Phase", 32'(bus.Phase), 32'd2);
        feed(P_PH4, 1);
        chk("t5_glitch_NewPhase", 32'(bus.NewPhase), 32'd0);
        feed(P_PH2, 2);
        chk("t5_Phase_after", 32'(bus.Phase), 32'd2);
        chk("t5_NewPhase_after", 32'(bus.NewPhase), 32'd0);

        // 6: reset mid-spin clears partial debounce too, then full -> HOLD
        feed(P_PH3, 2);
        chk("t6_Spinning", 32'(bus.Spinning), 32'd1);
        feed(P_PH4, 1);
        nReset = 1'b0; idle(1); nReset = 1'b1;
        chk_reset_vals("t6_reset");
        feed(P_PH4, 1);
        chk("t6_partial_cleared", 32'(bus.Phase), 32'd0);
        feed(P_FULL, 2);
        chk("t6_Phase_full", 32'(bus.Phase), 32'd5);
        chk("t6_Spinning_hold", 32'(bus.Spinning), 32'd0);
        feed(P_PH1, 2); feed(P_PH2, 2);
        chk("t6_hold_resync", 32'(bus.Spinning), 32'd1);

        // Randomized runs
        idx = 1;
        for (int run = 0; run < 1500; run++) begin
            pick = $urandom_range(0, 99);
            if (pick < 45)      begin idx = (idx + 1) % 4; pat = ring[idx]; end
            else if (pick < 65) begin idx = (idx + 3) % 4; pat = ring[idx]; end
            else if (pick < 73) begin idx = (idx + 2) % 4; pat = ring[idx]; end
            else if (pick < 79) pat = P_BLANK;
            else if (pick < 85) pat = P_FULL;
            else if (pick < 92) pat = 8'($urandom_range(0, 127));
            else                pat = ring[idx];
            len = $urandom_range(1, 3);
            if ($urandom_range(0, 399) == 0) nReset = 1'b0;
            for (r = 0; r < len; r++) begin
                bus.SampleEn = ($urandom_range(0, 99) < 85);
                bus.SSegIn   = {1'($urandom_range(0, 1)), pat[6:0]};
                bus.ErrClr   = ($urandom_range(0, 99) < 5);
                @(posedge Clk); #1;
                nReset = 1'b1;
            end
        end
        bus.SampleEn = 1'b0; bus.ErrClr = 1'b0;
        idle(2);
        chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
